// File: rtl/tiny_pkg.sv
// Shared ISA encodings for the tiny core.
// Used by controlunit and inst_prefetch.
package tiny_pkg;

    localparam int OPC_W = 8;

    typedef enum logic [1:0] {
        T_MEM = 2'd0,
        T_JMP = 2'd1,
        T_ALU = 2'd2,
        T_SYS = 2'd3
    } op_type_e;

    localparam logic [OPC_W-1:0] OP_LOAD  = 8'd1;
    localparam logic [OPC_W-1:0] OP_STORE = 8'd2;
    localparam logic [OPC_W-1:0] OP_JUMP  = 8'd3;
    localparam logic [OPC_W-1:0] OP_JUMPZ = 8'd4;
    localparam logic [OPC_W-1:0] OP_ADD   = 8'd5;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'd6;
    localparam logic [OPC_W-1:0] OP_HALT  = 8'hFF;

    function automatic op_type_e op_type(
        input logic [OPC_W-1:0] opc
    );
        op_type_e t;
        t = T_SYS;
        unique case (1'b1)
            (opc == OP_LOAD) || (opc == OP_STORE):
                t = T_MEM;
            (opc == OP_JUMP) || (opc == OP_JUMPZ):
                t = T_JMP;
            (opc == OP_ADD) || (opc == OP_SUB):
                t = T_ALU;
            default:
                t = T_SYS;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Memory read port plus instruction handshake.
// master = prefetcher side, slave = memory/consumer side.
interface inst_prefetch_if #(
    parameter int WIDTH = 8
);
    import tiny_pkg::*;

    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             inst_valid;
    logic [OPC_W-1:0] inst_opcode;
    logic [WIDTH-1:0] inst_operand;
    logic             inst_ready;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] pc;

    modport master (
        output mem_req, mem_addr,
        output inst_valid, inst_opcode,
        output inst_operand, pc,
        input  mem_rdata, inst_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr,
        input  inst_valid, inst_opcode,
        input  inst_operand, pc,
        output mem_rdata, inst_ready,
        output redirect, redirect_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush.
// Storage is not reset; only pointers and count.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_prefetch.sv
// Two-word instruction prefetcher: opcode then operand.
// Fetches ahead into a small queue; redirect flushes.
module inst_prefetch
    import tiny_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 100
) (
    input logic             clk,
    input logic             reset,
    inst_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = OPC_W + WIDTH;

    typedef enum logic [1:0] {
        S_OP,
        S_ARG,
        S_FULL
    } state_e;

    state_e           state;
    state_e           state_nx;
    logic [WIDTH-1:0] pc;
    logic             pending;
    logic [OPC_W-1:0] hold;
    logic             rsp_op;
    logic             rsp_arg;
    logic [CW-1:0]    count;
    logic [CW:0]      occ;
    logic [EW-1:0]    head;
    logic             room;
    logic             issue;
    logic             push;
    logic             pop;
    logic             valid;

    // Pending counts the instruction whose words are in flight.
    assign occ  = {1'b0, count} + {{CW{1'b0}}, pending};
    assign room = (occ < (CW + 1)'(DEPTH));

    assign valid = (count != '0);
    assign push  = rsp_arg & ~bus.redirect;
    assign pop   = valid & bus.inst_ready & ~bus.redirect;

    assign bus.mem_req      = issue & reset;
    assign bus.mem_addr     = pc;
    assign bus.pc           = pc;
    assign bus.inst_valid   = valid;
    assign bus.inst_opcode  = valid ? head[EW-1 -: OPC_W] : '0;
    assign bus.inst_operand = valid ? head[WIDTH-1:0] : '0;

    // Next state and issue decision; redirect suppresses issue.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            S_OP: begin
                if (room) begin
                    issue    = 1'b1;
                    state_nx = S_ARG;
                end else begin
                    state_nx = S_FULL;
                end
            end
            S_ARG: begin
                issue    = 1'b1;
                state_nx = S_OP;
            end
            S_FULL: begin
                if (room)
                    state_nx = S_OP;
            end
            default: state_nx = S_OP;
        endcase
        if (bus.redirect) begin
            issue    = 1'b0;
            state_nx = S_OP;
        end
    end

    // State, pc, in-flight tracking and opcode hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_OP;
            pc      <= WIDTH'(RESET_PC);
            pending <= 1'b0;
            hold    <= '0;
            rsp_op  <= 1'b0;
            rsp_arg <= 1'b0;
        end else begin
            state   <= state_nx;
            rsp_op  <= issue && (state == S_OP);
            rsp_arg <= issue && (state == S_ARG);
            if (bus.redirect) begin
                pc      <= bus.redirect_pc;
                pending <= 1'b0;
            end else begin
                if (issue)
                    pc <= pc + 1'b1;
                if (issue && (state == S_OP))
                    pending <= 1'b1;
                else if (push)
                    pending <= 1'b0;
                if (rsp_op)
                    hold <= bus.mem_rdata[OPC_W-1:0];
            end
        end
    end

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .din   ({hold, bus.mem_rdata}),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch with a memory model
// and a scoreboard of expected opcode/operand pairs.
module tb_inst_prefetch;

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
    } pair_t;

    logic       clk;
    logic       reset;
    logic [7:0] mem [256];
    pair_t      sb [$];
    int         n_cmp;
    int         n_bad;

    inst_prefetch_if #(.WIDTH(8)) bus ();

    inst_prefetch #(
        .WIDTH    (8),
        .DEPTH    (4),
        .RESET_PC (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after each request.
    always @(posedge clk) begin
        if (bus.mem_req)
            bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a);
        logic [7:0] b;
        b = a + 8'd1;
        sb.push_back('{mem[a], mem[b]});
    endtask

    task automatic consume(input int budget);
        pair_t e;
        int    k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            if (bus.inst_valid && bus.inst_ready) begin
                e = sb.pop_front();
                check("op", 32'(bus.inst_opcode), 32'(e.op));
                check("arg", 32'(bus.inst_operand),
                      32'(e.arg));
            end
            step();
            k++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic hold_reset();
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        step();
        step();
    endtask

    initial begin
        int         k;
        logic [7:0] a;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i * 7 + 3);
        mem[100] = 8'd1;
        mem[101] = 8'd13;
        mem[102] = 8'd11;
        mem[103] = 8'd10;
        mem[104] = 8'd66;
        mem[105] = 8'd13;
        mem[106] = 8'd69;
        mem[107] = 8'd99;
        bus.mem_rdata  = '0;
        bus.inst_ready = 1'b1;

        // Reset values
        hold_reset();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd100);
        check("rst_opc", 32'(bus.inst_opcode), 32'd0);
        check("rst_opd", 32'(bus.inst_operand), 32'd0);

        // Streaming with consumer always ready
        reset = 1'b1;
        #1;
        check("t1_req", 32'(bus.mem_req), 32'd1);
        check("t1_addr", 32'(bus.mem_addr), 32'd100);
        push_pair(8'd100);
        push_pair(8'd102);
        push_pair(8'd104);
        push_pair(8'd106);
        k = 0;
        while (!bus.inst_valid && k < 10) begin
            step();
            k++;
        end
        check("t1_latency", 32'(k), 32'd3);
        consume(40);

        // Consumer stalled: queue fills and fetch stops
        hold_reset();
        bus.inst_ready = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++)
            step();
        check("t2_req", 32'(bus.mem_req), 32'd0);
        check("t2_pc", 32'(bus.pc), 32'd108);
        check("t2_valid", 32'(bus.inst_valid), 32'd1);
        check("t2_opc", 32'(bus.inst_opcode), 32'd1);
        check("t2_opd", 32'(bus.inst_operand), 32'd13);
        push_pair(8'd100);
        push_pair(8'd102);
        push_pair(8'd104);
        push_pair(8'd106);
        push_pair(8'd108);
        bus.inst_ready = 1'b1;
        consume(60);

        // Redirect while operand response is in flight
        hold_reset();
        reset = 1'b1;
        step();
        check("t3_arg_addr", 32'(bus.mem_addr), 32'd101);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'd50;
        #1;
        check("t3_redir_req", 32'(bus.mem_req), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        check("t3_req", 32'(bus.mem_req), 32'd1);
        check("t3_addr", 32'(bus.mem_addr), 32'd50);
        check("t3_valid", 32'(bus.inst_valid), 32'd0);
        push_pair(8'd50);
        consume(20);

        // Redirect together with pop on a full queue
        hold_reset();
        bus.inst_ready = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++)
            step();
        check("t4_full", 32'(bus.pc), 32'd108);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'd200;
        bus.inst_ready  = 1'b1;
        step();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        #1;
        check("t4_valid", 32'(bus.inst_valid), 32'd0);
        check("t4_opc", 32'(bus.inst_opcode), 32'd0);
        check("t4_opd", 32'(bus.inst_operand), 32'd0);
        push_pair(8'd200);
        bus.inst_ready = 1'b1;
        consume(20);

        // Address wrap after redirect to 254
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'd254;
        step();
        bus.redirect = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            a = 8'd254 + 8'(i);
            check("t5_req", 32'(bus.mem_req), 32'd1);
            check("t5_addr", 32'(bus.mem_addr), 32'(a));
            step();
        end
        push_pair(8'd254);
        push_pair(8'd0);
        bus.inst_ready = 1'b1;
        consume(20);

        // Reset in the operand-issue cycle
        hold_reset();
        reset = 1'b1;
        step();
        check("t6_arg_addr", 32'(bus.mem_addr), 32'd101);
        reset = 1'b0;
        #1;
        check("t6_req", 32'(bus.mem_req), 32'd0);
        check("t6_valid", 32'(bus.inst_valid), 32'd0);
        check("t6_pc", 32'(bus.pc), 32'd100);
        step();
        step();
        reset = 1'b1;
        #1;
        check("t6_rel_req", 32'(bus.mem_req), 32'd1);
        check("t6_rel_addr", 32'(bus.mem_addr), 32'd100);
        push_pair(8'd100);
        consume(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data/address word width.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 100, SHALL set the first fetch address after reset.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mem_req  output  1  read request to memory this cycle.
REQ-007 mem_addr  output  WIDTH  read address, valid when mem_req=1.
REQ-008 mem_rdata  input  WIDTH  read data, valid exactly one cycle after the mem_req cycle.
REQ-009 inst_valid  output  1  queue head holds a complete instruction.
REQ-010 inst_opcode  output  8  head opcode word (low 8 bits of fetched word).
REQ-011 inst_operand  output  WIDTH  head operand word.
REQ-012 inst_ready  input  1  consumer takes head when inst_valid & inst_ready.
REQ-013 redirect  input  1  taken jump; flush queue and refetch.
REQ-014 redirect_pc  input  WIDTH  new fetch address, sampled when redirect=1.
REQ-015 pc  output  WIDTH  next address to be requested.

Function
REQ-016 Each instruction SHALL be two consecutive words: opcode at pc, operand at pc+1.
REQ-017 FSM states SHALL be S_OP (issue opcode read), S_ARG (issue operand read), S_FULL (no issue).
REQ-018 In S_OP, if count + pending < DEPTH, mem_req=1, mem_addr=pc, pc<=pc+1, pending<=1, go S_ARG; else go S_FULL.
REQ-019 In S_ARG, mem_req=1, mem_addr=pc, pc<=pc+1, go S_OP.
REQ-020 S_FULL SHALL leave to S_OP in the cycle after count + pending < DEPTH becomes true.
REQ-021 Opcode data SHALL be captured into a hold register the cycle after its request; operand data SHALL push {hold, operand} into the queue the cycle after its request and clear pending.
REQ-022 pc SHALL wrap modulo 2^WIDTH (e.g. 255+1 -> 0 at WIDTH=8).
REQ-023 Head-to-consumer latency: first inst_valid SHALL assert 3 cycles after the first S_OP request cycle.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; pop with inst_valid=0 SHALL be ignored.
REQ-025 Queue SHALL never overflow; full throughput SHALL be one instruction per two cycles.
REQ-026 redirect=1 SHALL, at that edge: pc<=redirect_pc, count<=0, pending<=0, state<=S_OP, and any response arriving next cycle SHALL be discarded.
REQ-027 redirect SHALL take priority over simultaneous pop, push and issue; mem_req SHALL be 0 in the redirect cycle.
REQ-028 inst_opcode/inst_operand SHALL hold stable while inst_valid=1 and inst_ready=0.

Reset
REQ-029 On reset low: pc=RESET_PC, state=S_OP, count=0, pending=0, hold=0, inst_valid=0, mem_req=0, queue pointers=0.
REQ-030 Reset asserted mid-fetch SHALL abandon in-flight reads; first request after release SHALL be to RESET_PC.
REQ-031 Queue storage contents need not be reset; outputs SHALL read 0 while inst_valid=0.

Structure
REQ-032 Opcode constants (load, store, jump, jumpz, add, ...) and type-field encodings SHALL live in shared package tiny_pkg, also used by controlunit.
REQ-033 State enum SHALL be declared locally in inst_prefetch.
REQ-034 Queue SHALL be a sub-module sync_fifo (WIDTH+8 bits, DEPTH entries, push/pop/count).

Verification
REQ-035 Memory 100..107 = {1,13,11,10,66,13,69,99}, inst_ready=1 -> pairs (1,13),(11,10),(66,13),(69,99) in order, first valid 3 cycles after first request.
REQ-036 inst_ready=0 for 20 cycles -> exactly 4 entries queued, mem_req=0 thereafter, head stays (1,13).
REQ-037 redirect=1, redirect_pc=50 while operand in flight -> that response discarded, next mem_addr=50, next valid pair from 50/51.
REQ-038 redirect and pop same cycle with queue full -> count=0, inst_valid=0 next cycle.
REQ-039 redirect_pc=254, WIDTH=8 -> requests 254,255,0,1; pairs (m[254],m[255]),(m[0],m[1]).
REQ-040 reset low during S_ARG -> all outputs reset values immediately; after release first mem_addr=100.
